// File: rtl/mips_wb_stage.sv
// MIPS write-back stage: MEM/WB entry register, load alignment/extension,
// register-file write-port arbitration against the mul/div unit, retire counter.
module mips_wb_stage #(
   parameter int unsigned DW         = 32,
   parameter int unsigned RW         = 5,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic          mem_flush,
   input  logic          mem_dest_en,
   input  logic [RW-1:0] mem_dest_idx,
   input  logic [DW-1:0] mem_alu_dat,
   input  logic          mem_is_load,
   input  logic [1:0]    mem_ld_size,
   input  logic          mem_ld_uns,
   input  logic [1:0]    mem_addr_lo,
   input  logic [DW-1:0] mem_rdat,
   input  logic          md_valid,
   output logic          md_ready,
   input  logic [RW-1:0] md_idx,
   input  logic [DW-1:0] md_dat,
   output logic          wb_dest_en,
   output logic [RW-1:0] wb_dest_idx,
   output logic [DW-1:0] wb_dest_dat,
   output logic          wb_excp,
   output logic [31:0]   wb_instret
);

   localparam int unsigned   CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic          e_vld;
   logic          e_dest_en;
   logic          e_excp;
   logic [RW-1:0] e_idx;
   logic [DW-1:0] e_dat;

   logic [CW-1:0] starve_cnt;
   logic [CW-1:0] starve_nxt;

   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [DW-1:0] ld_dat;
   logic [DW-1:0] cap_dat;
   logic          misal;
   logic          cap_excp;
   logic          capture;
   logic          pipe_wr;

   always_comb begin
      ld_byte = mem_rdat[7:0];
      ld_half = mem_rdat[15:0];
      ld_dat  = mem_rdat;
      misal   = 1'b0;
      case (mem_addr_lo)
         2'd0:    ld_byte = mem_rdat[7:0];
         2'd1:    ld_byte = mem_rdat[15:8];
         2'd2:    ld_byte = mem_rdat[23:16];
         default: ld_byte = mem_rdat[31:24];
      endcase
      if (mem_addr_lo[1]) ld_half = mem_rdat[31:16];
      case (mem_ld_size)
         2'd0: begin
            ld_dat = mem_ld_uns ? {{(DW-8){1'b0}}, ld_byte}
                                : {{(DW-8){ld_byte[7]}}, ld_byte};
         end
         2'd1: begin
            ld_dat = mem_ld_uns ? {{(DW-16){1'b0}}, ld_half}
                                : {{(DW-16){ld_half[15]}}, ld_half};
            misal  = mem_addr_lo[0];
         end
         default: begin
            ld_dat = mem_rdat;
            misal  = |mem_addr_lo;
         end
      endcase
      cap_excp = mem_is_load & misal;
      cap_dat  = mem_is_load ? ld_dat : mem_alu_dat;
   end

   assign mem_ready = (starve_cnt != CNT_MAX);
   assign capture   = mem_valid & mem_ready & ~mem_flush;
   assign pipe_wr   = e_vld & e_dest_en & ~e_excp & (e_idx != '0);
   assign wb_excp   = e_vld & e_excp;

   // The mul/div side is gated by rst_n so the port stays silent during reset.
   always_comb begin
      md_ready    = 1'b0;
      wb_dest_en  = 1'b0;
      wb_dest_idx = '0;
      wb_dest_dat = '0;
      if (pipe_wr) begin
         wb_dest_en  = 1'b1;
         wb_dest_idx = e_idx;
         wb_dest_dat = e_dat;
      end else if (rst_n) begin
         md_ready    = md_valid;
         wb_dest_en  = md_valid & (md_idx != '0);
         wb_dest_idx = md_idx;
         wb_dest_dat = md_dat;
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (!md_valid || md_ready)     starve_nxt = '0;
      else if (starve_cnt != CNT_MAX) starve_nxt = starve_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_vld      <= 1'b0;
         e_dest_en  <= 1'b0;
         e_excp     <= 1'b0;
         e_idx      <= '0;
         e_dat      <= '0;
         starve_cnt <= '0;
         wb_instret <= '0;
      end else begin
         e_vld      <= capture;
         starve_cnt <= starve_nxt;
         if (capture) begin
            e_dest_en <= mem_dest_en & ~cap_excp;
            e_excp    <= cap_excp;
            e_idx     <= mem_dest_idx;
            e_dat     <= cap_dat;
         end
         if (e_vld && !e_excp) wb_instret <= wb_instret + 32'd1;
      end
   end

endmodule

// File: tb/tb_mips_wb_stage.sv
// Directed bench for mips_wb_stage: driver pushes expected port writes into a
// scoreboard queue, a negedge monitor pops and compares whenever the port fires.
module tb_mips_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_ready, mem_flush, mem_dest_en;
   logic [4:0]  mem_dest_idx;
   logic [31:0] mem_alu_dat, mem_rdat;
   logic        mem_is_load, mem_ld_uns;
   logic [1:0]  mem_ld_size, mem_addr_lo;
   logic        md_valid, md_ready;
   logic [4:0]  md_idx;
   logic [31:0] md_dat;
   logic        wb_dest_en, wb_excp;
   logic [4:0]  wb_dest_idx;
   logic [31:0] wb_dest_dat, wb_instret;

   mips_wb_stage #(.DW(32), .RW(5), .STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_flush(mem_flush),
      .mem_dest_en(mem_dest_en), .mem_dest_idx(mem_dest_idx), .mem_alu_dat(mem_alu_dat),
      .mem_is_load(mem_is_load), .mem_ld_size(mem_ld_size), .mem_ld_uns(mem_ld_uns),
      .mem_addr_lo(mem_addr_lo), .mem_rdat(mem_rdat),
      .md_valid(md_valid), .md_ready(md_ready), .md_idx(md_idx), .md_dat(md_dat),
      .wb_dest_en(wb_dest_en), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat),
      .wb_excp(wb_excp), .wb_instret(wb_instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [4:0]  idx;
      logic [31:0] dat;
      logic        excp;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned exp_instret = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (wb_dest_en === 1'b1 || wb_excp === 1'b1)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: en=%0b idx=%0d dat=0x%08h excp=%0b, expected no output",
                     wb_dest_en, wb_dest_idx, wb_dest_dat, wb_excp);
         end else begin
            mon_e = sb.pop_front();
            check("wb_dest_en", 32'(wb_dest_en), 32'(mon_e.en));
            check("wb_excp", 32'(wb_excp), 32'(mon_e.excp));
            if (mon_e.en) begin
               check("wb_dest_idx", 32'(wb_dest_idx), 32'(mon_e.idx));
               check("wb_dest_dat", wb_dest_dat, mon_e.dat);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic en, input logic [4:0] idx, input logic ld,
                          input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                          input logic [31:0] d, input logic fl);
      mem_valid    = 1'b1;
      mem_flush    = fl;
      mem_dest_en  = en;
      mem_dest_idx = idx;
      mem_is_load  = ld;
      mem_ld_size  = sz;
      mem_ld_uns   = uns;
      mem_addr_lo  = lo;
      mem_alu_dat  = ld ? ~d : d;
      mem_rdat     = ld ? d : ~d;
   endtask

   task automatic expect_mem(input logic en, input logic [4:0] idx, input logic fl,
                             input logic [31:0] ed, input logic ee);
      if (!fl) begin
         if (ee) sb.push_back('{en: 1'b0, idx: 5'd0, dat: 32'd0, excp: 1'b1});
         else if (en && idx != 5'd0) sb.push_back('{en: 1'b1, idx: idx, dat: ed, excp: 1'b0});
         if (!ee) exp_instret++;
      end
   endtask

   task automatic xfer(input logic en, input logic [4:0] idx, input logic ld,
                       input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                       input logic [31:0] d, input logic fl, input logic [31:0] ed,
                       input logic ee);
      set_mem(en, idx, ld, sz, uns, lo, d, fl);
      #1 check("mem_ready_xfer", 32'(mem_ready), 32'd1);
      expect_mem(en, idx, fl, ed, ee);
      tick();
      mem_valid = 1'b0;
      mem_flush = 1'b0;
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
      check({tag, "_md_ready"}, 32'(md_ready), 32'd0);
      check({tag, "_wb_dest_en"}, 32'(wb_dest_en), 32'd0);
      check({tag, "_wb_dest_idx"}, 32'(wb_dest_idx), 32'd0);
      check({tag, "_wb_dest_dat"}, wb_dest_dat, 32'd0);
      check({tag, "_wb_excp"}, 32'(wb_excp), 32'd0);
      check({tag, "_wb_instret"}, wb_instret, 32'd0);
   endtask

   initial begin
      logic done;
      rst_n = 1'b0;
      mem_valid = 0; mem_flush = 0; mem_dest_en = 0; mem_dest_idx = 0;
      mem_alu_dat = 0; mem_rdat = 0; mem_is_load = 0; mem_ld_size = 0;
      mem_ld_uns = 0; mem_addr_lo = 0;
      md_valid = 1'b1; md_idx = 5'd3; md_dat = 32'h5;
      #2 reset_outputs("reset");
      md_valid = 1'b0; md_idx = 0; md_dat = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Loads: alignment, sign/zero extension, misalignment exceptions
      xfer(1, 5'd3, 1, 2'd0, 0, 2'd3, 32'h80FF_1234, 0, 32'hFFFF_FF80, 0);
      tick(); tick();
      check("instret_after_lb", wb_instret, 32'd1);
      xfer(1, 5'd4, 1, 2'd0, 1, 2'd1, 32'h80FF_1234, 0, 32'h0000_0012, 0);
      xfer(1, 5'd5, 1, 2'd0, 0, 2'd2, 32'h80FF_1234, 0, 32'hFFFF_FFFF, 0);
      xfer(1, 5'd6, 1, 2'd0, 1, 2'd0, 32'h0000_00F0, 0, 32'h0000_00F0, 0);
      xfer(1, 5'd7, 1, 2'd1, 0, 2'd0, 32'h1234_8765, 0, 32'hFFFF_8765, 0);
      xfer(1, 5'd8, 1, 2'd1, 1, 2'd2, 32'h8001_0000, 0, 32'h0000_8001, 0);
      xfer(1, 5'd9, 1, 2'd1, 0, 2'd2, 32'h8001_0000, 0, 32'hFFFF_8001, 0);
      xfer(1, 5'd10, 1, 2'd2, 0, 2'd2, 32'h1111_2222, 0, 32'h0, 1);
      xfer(1, 5'd11, 1, 2'd1, 0, 2'd1, 32'h3333_4444, 0, 32'h0, 1);
      xfer(1, 5'd12, 1, 2'd2, 0, 2'd0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0);
      xfer(1, 5'd13, 1, 2'd3, 0, 2'd0, 32'h0123_4567, 0, 32'h0123_4567, 0);
      xfer(1, 5'd14, 0, 2'd0, 0, 2'd3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
      tick(); tick();
      check("instret_after_loads", wb_instret, exp_instret);

      // Starvation guard: ALU stream to r5 with a pending mul/div result for r7
      xfer(1, 5'd5, 0, 2'd0, 0, 2'd0, 32'h0000_0100, 0, 32'h0000_0100, 0);
      md_valid = 1'b1; md_idx = 5'd7; md_dat = 32'h0000_0777;
      for (int k = 0; k < 3; k++) begin
         set_mem(1, 5'd5, 0, 2'd0, 0, 2'd0, 32'h0000_0101 + 32'(k), 0);
         #1 check("starve_mem_ready", 32'(mem_ready), 32'd1);
         check("starve_md_ready", 32'(md_ready), 32'd0);
         expect_mem(1, 5'd5, 0, 32'h0000_0101 + 32'(k), 0);
         tick();
      end
      sb.push_back('{en: 1'b1, idx: 5'd7, dat: 32'h0000_0777, excp: 1'b0});
      set_mem(1, 5'd5, 0, 2'd0, 0, 2'd0, 32'h0000_0200, 0);
      #1 check("held_off_mem_ready", 32'(mem_ready), 32'd0);
      check("held_off_md_ready", 32'(md_ready), 32'd0);
      tick();
      #1 check("md_wins_md_ready", 32'(md_ready), 32'd1);
      done = mem_ready;
      if (done) expect_mem(1, 5'd5, 0, 32'h0000_0200, 0);
      tick();
      md_valid = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
         #1 done = mem_ready;
         if (done) expect_mem(1, 5'd5, 0, 32'h0000_0200, 0);
         tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL mem_ready_recover: got 0, expected 1 within 5 cycles");
      end
      mem_valid = 1'b0;
      tick(); tick();
      check("instret_after_starve", wb_instret, exp_instret);

      // dest_idx=0 transfer lets mul/div take the port the next cycle
      xfer(1, 5'd4, 0, 2'd0, 0, 2'd0, 32'h0000_0044, 0, 32'h0000_0044, 0);
      md_valid = 1'b1; md_idx = 5'd12; md_dat = 32'h0000_C0C0;
      set_mem(1, 5'd0, 0, 2'd0, 0, 2'd0, 32'h0000_0099, 0);
      #1 check("r0_cycle_md_ready", 32'(md_ready), 32'd0);
      expect_mem(1, 5'd0, 0, 32'h0000_0099, 0);
      sb.push_back('{en: 1'b1, idx: 5'd12, dat: 32'h0000_C0C0, excp: 1'b0});
      tick();
      mem_valid = 1'b0;
      #1 check("r0_next_md_ready", 32'(md_ready), 32'd1);
      check("r0_next_wb_dest_idx", 32'(wb_dest_idx), 32'd12);
      tick();
      md_idx = 5'd0; md_dat = 32'h0000_1234;
      #1 check("md_idx0_md_ready", 32'(md_ready), 32'd1);
      check("md_idx0_wb_dest_en", 32'(wb_dest_en), 32'd0);
      tick();
      md_valid = 1'b0;
      tick(); tick();
      check("instret_after_r0", wb_instret, exp_instret);

      // Flush: squashed transfer writes nothing, entry already in WB is kept
      xfer(1, 5'd6, 0, 2'd0, 0, 2'd0, 32'h0000_0066, 1, 32'h0, 0);
      tick(); tick();
      check("instret_after_flush", wb_instret, exp_instret);
      xfer(1, 5'd10, 0, 2'd0, 0, 2'd0, 32'h0000_00AA, 0, 32'h0000_00AA, 0);
      xfer(1, 5'd11, 0, 2'd0, 0, 2'd0, 32'h0000_00BB, 1, 32'h0, 0);
      tick(); tick();
      check("instret_after_flush2", wb_instret, exp_instret);

      // Reset mid-stream with a live entry in WB
      set_mem(1, 5'd8, 0, 2'd0, 0, 2'd0, 32'h0000_0088, 0);
      tick();
      mem_valid = 1'b0;
      #1 check("pre_reset_wb_dest_en", 32'(wb_dest_en), 32'd1);
      rst_n = 1'b0;
      #1 reset_outputs("midreset");
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check("post_reset_wb_dest_en", 32'(wb_dest_en), 32'd0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
